// File: rtl/oram_writer_pkg.sv
// Shared definitions for the oram writer: state encodings, the ARM return word and
// default geometry used by the writer and its neighbouring translator stages.
package oram_writer_pkg;

  typedef enum logic [2:0] {
    WR_IDLE  = 3'd0,
    WR_RUN   = 3'd1,
    WR_FLUSH = 3'd2,
    WR_TERM  = 3'd3,
    WR_DONE  = 3'd4,
    WR_OVF   = 3'd5
  } wr_state_e;

  localparam logic [31:0] ARM_BX_LR      = 32'hE12FFF1E;
  localparam int          FIFO_DEPTH_DEF = 4;
  localparam int          ORAM_AW_DEF    = 10;

  function automatic logic accepts_input(input wr_state_e s);
    return (s == WR_IDLE) || (s == WR_RUN);
  endfunction

  function automatic logic drains_fifo(input wr_state_e s);
    return (s == WR_RUN) || (s == WR_FLUSH);
  endfunction

  function automatic logic writes_return(input wr_state_e s);
    return (s == WR_TERM) || (s == WR_OVF);
  endfunction

endpackage

// File: rtl/oram_writer_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; clr empties it synchronously and
// overrides any push in the same cycle. Storage is not reset, only the pointers.
module oram_writer_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW:0]       wr_ptr_q, wr_ptr_d;
  logic [PW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_pop   = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO may push and pop together.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/oram_writer.sv
// Output stage of the JVM->ARM translator: buffers translated words, commits them to
// oram, appends BX LR at end of method. Define ORAM_CHECKSUM_EN for the XOR checksum port.
module oram_writer
  import oram_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ORAM_AW    = ORAM_AW_DEF,
  parameter int ORAM_BASE  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        data,
  input  logic               start,
  output logic               ready,
  input  logic               finish,
  input  logic               restart,
  input  logic               oram_gnt,
  output logic               oram_we,
  output logic [ORAM_AW-1:0] oram_addr,
  output logic [31:0]        oram_wdata,
  output logic [ORAM_AW:0]   word_count,
  output logic               done,
  output logic               overflow
`ifdef ORAM_CHECKSUM_EN
  ,
  output logic [31:0]        checksum
`endif
);

  localparam logic [ORAM_AW-1:0] BASE_ADDR = ORAM_AW'(ORAM_BASE);
  localparam logic [ORAM_AW-1:0] LAST_ADDR = ORAM_AW'(ORAM_BASE + (1 << ORAM_AW) - 1);

  wr_state_e          state_q, state_d;
  logic [ORAM_AW-1:0] addr_q, addr_d;
  logic [ORAM_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic        fifo_full, fifo_empty, fifo_clr;
  logic [31:0] fifo_rdata;
  logic        accept, at_last, wr_data, wr_ret;

  assign at_last = (addr_q == LAST_ADDR);

  // ready is forced low while reset is held, even though the state already reads IDLE.
  assign ready   = reset && !fifo_full && accepts_input(state_q);
  assign accept  = start && ready && !restart;

  // The last oram slot is kept for the return word; data words never land there.
  assign wr_data = drains_fifo(state_q) && !fifo_empty && oram_gnt && !at_last && !restart;
  assign wr_ret  = writes_return(state_q) && oram_gnt && !restart;

  assign oram_we    = wr_data || wr_ret;
  assign oram_wdata = wr_ret ? ARM_BX_LR : (wr_data ? fifo_rdata : 32'h0);
  assign oram_addr  = addr_q;
  assign word_count = count_q;
  assign done       = (state_q == WR_DONE);
  assign overflow   = ovf_q;

  // Pending words are dropped once capacity is exhausted.
  assign fifo_clr = restart || (state_q == WR_OVF);

  oram_writer_sync_fifo #(
    .DATA_W (32),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .clr       (fifo_clr),
    .push      (accept),
    .push_data (data),
    .pop       (wr_data),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (oram_we) begin
      addr_d  = addr_q + ORAM_AW'(1);
      count_d = count_q + (ORAM_AW+1)'(1);
    end

    case (state_q)
      WR_IDLE: begin
        // A word accepted alongside finish must still be written before BX LR.
        if (finish)      state_d = accept ? WR_FLUSH : WR_TERM;
        else if (accept) state_d = WR_RUN;
      end
      WR_RUN: begin
        if (!fifo_empty && at_last) begin
          state_d = WR_OVF;
          ovf_d   = 1'b1;
        end else if (finish) begin
          state_d = WR_FLUSH;
        end
      end
      WR_FLUSH: begin
        if (!fifo_empty && at_last) begin
          state_d = WR_OVF;
          ovf_d   = 1'b1;
        end else if (fifo_empty) begin
          state_d = WR_TERM;
        end
      end
      WR_TERM:  if (oram_gnt) state_d = WR_DONE;
      WR_OVF:   if (oram_gnt) state_d = WR_DONE;
      WR_DONE:  state_d = WR_DONE;
      default:  state_d = WR_IDLE;
    endcase

    if (restart) begin
      state_d = WR_IDLE;
      addr_d  = BASE_ADDR;
      count_d = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WR_IDLE;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef ORAM_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (restart)      csum_d = '0;
    else if (oram_we) csum_d = csum_q ^ oram_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign checksum = csum_q;
`endif

endmodule
